// File: rtl/vcmd_pkg.sv
// rtl/vcmd_pkg.sv - shared constants and types for the VGA command path
package vcmd_pkg;

  // Opcodes shared with the command decoder
  localparam logic [7:0] OP_NOOP     = 8'h00;
  localparam logic [7:0] OP_BUF_SWAP = 8'h01;
  localparam logic [7:0] OP_SET_X    = 8'h20;
  localparam logic [7:0] OP_SET_Y    = 8'h30;
  localparam logic [7:0] OP_WRITE_NU = 8'h42;
  localparam logic [7:0] OP_WRITE_NP = 8'h43;

  // FIFO entry: first-of-frame tag plus data byte
  localparam int FIFO_EW = 9;

  // Receive FSM encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef struct packed {
    logic       tag;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/vcmd_spi_rx_if.sv
// rtl/vcmd_spi_rx_if.sv - SPI and command-byte signals of vcmd_spi_rx (VCMD_SPI_MISO_EN adds spi_miso)
interface vcmd_spi_rx_if #(
  parameter int FIFO_AW = 3
);
  logic               spi_sck;
  logic               spi_mosi;
  logic               spi_cs_n;
  logic               cmd_ready;
  logic               cmd_recv;
  logic               cmd_recv_int;
  logic [7:0]         cmd_in;
  logic               overflow;
  logic [FIFO_AW:0]   fifo_level;
`ifdef VCMD_SPI_MISO_EN
  logic               spi_miso;

  modport master (
    output spi_sck, spi_mosi, spi_cs_n, cmd_ready,
    input  cmd_recv, cmd_recv_int, cmd_in, overflow, fifo_level, spi_miso
  );

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n, cmd_ready,
    output cmd_recv, cmd_recv_int, cmd_in, overflow, fifo_level, spi_miso
  );
`else
  modport master (
    output spi_sck, spi_mosi, spi_cs_n, cmd_ready,
    input  cmd_recv, cmd_recv_int, cmd_in, overflow, fifo_level
  );

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n, cmd_ready,
    output cmd_recv, cmd_recv_int, cmd_in, overflow, fifo_level
  );
`endif
endinterface

// File: rtl/vcmd_byte_fifo.sv
// rtl/vcmd_byte_fifo.sv - parameterised synchronous FIFO with push/pop/full/empty/level
module vcmd_byte_fifo #(
  parameter int AW = 3,
  parameter int DW = 9
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_pop_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level    = r_wptr - r_rptr;
  assign o_pop_data = r_mem[r_rptr[AW-1:0]];
  assign w_do_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken
  assign w_do_push  = i_push && (!o_full || w_do_pop);

  // Storage write; no reset needed since pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end
  end

  // Pointer advance on accepted push/pop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/vcmd_spi_rx.sv
// rtl/vcmd_spi_rx.sv - SPI mode-0 byte receiver feeding the command decoder (VCMD_SPI_MISO_EN adds status readback)
module vcmd_spi_rx
  import vcmd_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic           i_clk,
  input  logic           i_reset,
  vcmd_spi_rx_if.slave   bus
);
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic                   r_sck_hist;
  logic                   r_csn_hist;
  logic                   w_sck;
  logic                   w_mosi;
  logic                   w_csn;
  logic                   w_sck_rise;
  logic                   w_cs_fall;

  logic [0:0]             r_state;
  logic [2:0]             r_bitcnt;
  logic [6:0]             r_shreg;
  logic                   r_first;
  logic                   r_push;
  fifo_entry_t            r_push_entry;

  fifo_entry_t            w_pop_entry;
  logic                   w_full;
  logic                   w_empty;
  logic [FIFO_AW:0]       w_level;
  logic                   w_pop;

  logic                   r_cmd_recv;
  logic                   r_cmd_recv_int;
  logic [7:0]             r_cmd_in;
  logic                   r_overflow;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_csn      = r_csn_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_hist & ~w_csn;
  assign w_cs_fall  = ~w_csn & r_csn_hist;

  // Synchronisers; CsN chain clears low so a frame already open at reset release is not mistaken for a new CsFall
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_csn_sync  <= '0;
      r_sck_hist  <= 1'b0;
      r_csn_hist  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      r_sck_hist  <= w_sck;
      r_csn_hist  <= w_csn;
    end
  end

  // Receive FSM: assemble bytes MSB first, register the push toward the FIFO
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_bitcnt     <= 3'd0;
      r_shreg      <= 7'd0;
      r_first      <= 1'b0;
      r_push       <= 1'b0;
      r_push_entry <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bitcnt <= 3'd0;
          if (w_cs_fall) begin
            r_first <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_csn) begin
            r_bitcnt <= 3'd0;
            r_state  <= ST_IDLE;
          end else if (w_sck_rise) begin
            r_shreg  <= {r_shreg[5:0], w_mosi};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_push       <= 1'b1;
              r_push_entry <= {r_first, r_shreg, w_mosi};
              r_first      <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  vcmd_byte_fifo #(
    .AW (FIFO_AW),
    .DW (FIFO_EW)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (r_push),
    .i_push_data (r_push_entry),
    .i_pop       (bus.cmd_ready),
    .o_pop_data  (w_pop_entry),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  assign w_pop = bus.cmd_ready & ~w_empty;

  // Output strobe one cycle after pop; sticky overflow when a push finds the FIFO full with no pop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd_recv     <= 1'b0;
      r_cmd_recv_int <= 1'b0;
      r_cmd_in       <= 8'h00;
      r_overflow     <= 1'b0;
    end else begin
      r_cmd_recv     <= w_pop;
      r_cmd_recv_int <= w_pop & w_pop_entry.tag;
      if (w_pop) r_cmd_in <= w_pop_entry.data;
      if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign bus.cmd_recv     = r_cmd_recv;
  assign bus.cmd_recv_int = r_cmd_recv_int;
  assign bus.cmd_in       = r_cmd_in;
  assign bus.overflow     = r_overflow;
  assign bus.fifo_level   = w_level;

`ifdef VCMD_SPI_MISO_EN
  logic [7:0] r_miso_sh;
  logic       w_sck_fall;

  assign w_sck_fall = ~w_sck & r_sck_hist & ~w_csn;

  // Status byte loaded at frame start, shifted on each SCK falling edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_miso_sh <= 8'h00;
    end else if (w_cs_fall) begin
      r_miso_sh <= {r_overflow, 3'b000, 4'(w_level)};
    end else if (w_sck_fall) begin
      r_miso_sh <= {r_miso_sh[6:0], 1'b0};
    end
  end

  assign bus.spi_miso = ~w_csn & r_miso_sh[7];
`endif
endmodule
